seq_normalizer: RTL and testbench
=================================

Name: seq_normalizer

Overview:
- Iterative left-normalizer. It takes an N-bit word and finds the left-shift amount that normalizes it, then returns the normalized word and that shift amount.
- It is the inverse of the barrel shifter. The shifter applies a shift amount to a word; this block derives the shift amount from a word.
- Used ahead of FP/fixed-point datapaths. The returned shift_num can be fed back to the shifter (LSL/ASR) to undo or apply the same scaling.
- Binary-search over shift distances 2^(B-1) down to 1, one stage per clock, with valid/ready handshakes on input and output.

Parameters:
- N, 8, data width; power of two, N >= 4.
- B, $clog2(N), number of search stages and width of shift_num.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  num and signed_mode are valid.
- in_ready  output  1  block can accept an input.
- num  input  N  operand.
- signed_mode  input  1  0 = strip leading zeros; 1 = strip redundant sign bits (two's complement).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  N  normalized word.
- shift_num  output  B  left-shift distance applied to produce out.
- zero  output  1  operand was all-zeros.

Behaviour:
- Reset (synchronous, active-high on rst at clk edge):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, out = 0, shift_num = 0, zero = 0.
  - Reset mid-RUN or mid-DONE discards the in-flight operand; no out_valid pulse follows.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - capture num into work register W, and capture signed_mode; clear shift accumulator S and stage index k = B-1.
    - zero_r = (num == 0).
    - go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each cycle processes stage k with d = 2^k:
    - unsigned: if W[N-1 -: d] == 0, then W <= W << d and S[k] <= 1.
    - signed: if W[N-1 -: d+1] bits are all equal, then W <= W << d (zero fill) and S[k] <= 1.
    - otherwise W and S[k] are unchanged.
    - after k == 0, go to DONE.
    - RUN lasts exactly B cycles.
  - DONE: out_valid = 1, out = W, shift_num = S, zero = zero_r.
    - If zero_r = 1: out = 0 and shift_num = 0, regardless of search result.
    - out, shift_num and zero are held stable while out_valid & !out_ready.
    - On out_valid & out_ready, go to IDLE.
    - in_ready = 0 in DONE; no same-cycle re-accept.
- Latency: out_valid rises B+1 clocks after the accept edge.
- Throughput: one operation per B+2 cycles minimum.
- in_valid is ignored while in_ready = 0. num and signed_mode may change freely after the accept edge.
- Invariants for a nonzero result:
  - unsigned: out[N-1] = 1.
  - signed: out[N-1] != out[N-2].
  - out == num << shift_num (mod 2^N).
  - shift_num <= N-1, so it fits in B bits.
- Signed all-ones (-1): out = 1000..0, shift_num = N-1.
- Already normalized input: shift_num = 0, out = num.

Decomposition:
- Shared package normalizer_pkg:
  - state enum {IDLE, RUN, DONE}.
  - elaboration check that N is a power of two and N >= 4.
- One combinational sub-module, norm_stage:
  - params N and d; inputs w and signed_mode; outputs w_next and take.
  - implements the single-stage detect-and-shift.
  - instantiated once and driven by k through a d-select; alternatively B instances muxed by k.
- The FSM, counters and handshake stay in seq_normalizer.

Test Plan (N=8, B=3):
- Unsigned 0x01, out_ready=1 -> out=0x80, shift_num=7, zero=0; out_valid exactly 4 clocks after the accept edge, for one cycle.
- Unsigned 0x35 -> out=0xD4, shift_num=2. Unsigned 0x80 -> out=0x80, shift_num=0.
- Signed 0xF3 -> out=0x98, shift_num=3. Signed 0xFF -> out=0x80, shift_num=7. Signed 0x40 -> out=0x40, shift_num=0.
- Zero operand, 0x00 in both modes -> out=0x00, shift_num=0, zero=1. The next operation, 0x02 unsigned, returns zero=0, shift_num=6, out=0x80.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new num -> outputs stable, in_ready=0, new num not accepted. Release out_ready -> IDLE next cycle, in_ready=1.
- Assert rst during RUN, stage k=1 -> next cycle out_valid=0, in_ready=1, outputs zero; no stale result appears afterwards. Random sweep of all 256 values x 2 modes checks the invariants against a reference model.

Source files
------------

// File: rtl/seq_normalizer_pkg.sv
// Shared types and helpers for the iterative left-normalizer.
package seq_normalizer_pkg;

    // Controller states: waiting for an operand, searching, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal operand widths are powers of two no smaller than 4.
    function automatic bit width_ok(input int n);
        return (n >= 4) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/seq_normalizer_if.sv
// Operand/result handshake bundle for the left-normalizer.
interface seq_normalizer_if #(
    parameter int N = 8,
    parameter int B = $clog2(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] num;
    logic         signed_mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic [B-1:0] shift_num;
    logic         zero;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, num, signed_mode, out_ready,
        input  in_ready, out_valid, out, shift_num, zero
    );

    // The normalizer itself.
    modport slave (
        input  in_valid, num, signed_mode, out_ready,
        output in_ready, out_valid, out, shift_num, zero
    );
endinterface

// File: rtl/seq_normalizer_norm_stage.sv
// One binary-search step: decide whether the word can move left by D
// without losing information, and produce the shifted word if so.
module seq_normalizer_norm_stage #(
    parameter int N = 8,
    parameter int D = 1
) (
    input  logic [N-1:0] w,
    input  logic         signed_mode,
    output logic [N-1:0] w_next,
    output logic         take
);

    // Top D+1 bits: the unsigned test looks at the upper D of them, the
    // signed test needs one extra bit so the sign survives the shift.
    logic [D:0] top;
    assign top = w[N-1 -: D+1];

    // Detect a removable leading field and shift it out with zero fill.
    always_comb begin
        if (signed_mode) begin
            take = (top == '0) || (top == '1);
        end else begin
            take = (top[D:1] == '0);
        end
        w_next = take ? (w << D) : w;
    end

endmodule

// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: finds the left shift that removes leading
// zeros (unsigned) or redundant sign bits (signed), one search stage per
// clock from distance 2^(B-1) down to 1.
module seq_normalizer
    import seq_normalizer_pkg::*;
#(
    parameter int N = 8,
    parameter int B = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    seq_normalizer_if.slave  bus
);

    if (!width_ok(N) || (B != $clog2(N))) begin : g_bad_width
        $error("seq_normalizer: N must be a power of two >= 4 and B = clog2(N)");
    end

    localparam logic [B-1:0] K_FIRST = B'(B - 1);
    localparam logic [B-1:0] K_STEP  = B'(1);

    state_t       state;
    logic [N-1:0] w;
    logic [B-1:0] s;
    logic [B-1:0] k;
    logic         smode;
    logic         zero_r;

    logic         in_ready_r;
    logic         out_valid_r;
    logic [N-1:0] out_r;
    logic [B-1:0] shift_r;
    logic         zero_o;

    logic [N-1:0] stage_w [B];
    logic [B-1:0] stage_take;
    logic [N-1:0] w_sel;
    logic         take_sel;
    logic [B-1:0] s_next;

    // One search stage per shift distance; the active one is picked by k.
    for (genvar i = 0; i < B; i++) begin : g_stage
        seq_normalizer_norm_stage #(
            .N (N),
            .D (1 << i)
        ) u_stage (
            .w           (w),
            .signed_mode (smode),
            .w_next      (stage_w[i]),
            .take        (stage_take[i])
        );
    end

    // Select the current stage and fold its decision into the shift count.
    always_comb begin
        w_sel     = stage_w[k];
        take_sel  = stage_take[k];
        s_next    = s;
        s_next[k] = take_sel;
    end

    // Controller: accept, search for B cycles, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= '0;
            shift_r     <= '0;
            zero_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w          <= bus.num;
                        smode      <= bus.signed_mode;
                        s          <= '0;
                        k          <= K_FIRST;
                        zero_r     <= (bus.num == '0);
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    w <= w_sel;
                    s <= s_next;
                    if (k == '0) begin
                        // An all-zero operand reports no shift regardless of
                        // what the search did with it.
                        out_r       <= zero_r ? '0 : w_sel;
                        shift_r     <= zero_r ? '0 : s_next;
                        zero_o      <= zero_r;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k <= k - K_STEP;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.shift_num = shift_r;
    assign bus.zero      = zero_o;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed and exhaustive checks of seq_normalizer at N=8 against a
// leading-bit-count reference model, with a result scoreboard.
module tb_seq_normalizer;

    localparam int N = 8;
    localparam int B = 3;

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] sh;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_normalizer_if #(.N(N), .B(B)) bus ();

    seq_normalizer #(.N(N), .B(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: count leading zeros or redundant sign bits directly.
    function automatic exp_t model(input logic [7:0] n, input logic m);
        exp_t e;
        int   cnt;
        e.zero = (n == 8'h00);
        if (n == 8'h00) begin
            e.out = 8'h00;
            e.sh  = 3'd0;
            return e;
        end
        cnt = 0;
        if (!m) begin
            while (cnt < 8 && n[7-cnt] == 1'b0) cnt++;
        end else begin
            cnt = 1;
            while (cnt < 8 && n[7-cnt] == n[7]) cnt++;
            cnt--;
        end
        e.sh  = 3'(cnt);
        e.out = n << cnt;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic start_op(input logic [7:0] n, input logic m);
        sb.push_back(model(n, m));
        bus.num         = n;
        bus.signed_mode = m;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.num         = 8'($urandom);
        bus.signed_mode = 1'($urandom);
    endtask

    // Cycle count starts at 1 for the first cycle after the accept edge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid !== 1'b1) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_out"},   32'(bus.out),       32'(e.out));
        check({tag, "_shift"}, 32'(bus.shift_num), 32'(e.sh));
        check({tag, "_zero"},  32'(bus.zero),      32'(e.zero));
    endtask

    // Full operation with out_ready held high; ends back in IDLE at a negedge.
    task automatic do_op(input string tag, input logic [7:0] n, input logic m);
        int lat;
        start_op(n, m);
        wait_out(lat);
        compare_out(tag);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         seen;
        logic [7:0] vv;

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.num         = 8'h00;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out",       32'(bus.out),       32'd0);
        check("rst_shift",     32'(bus.shift_num), 32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);

        // First operation: latency and single-cycle result.
        start_op(8'h01, 1'b0);
        check("busy_in_ready", 32'(bus.in_ready), 32'd0);
        wait_out(lat);
        check("latency", 32'(lat), 32'(B + 1));
        compare_out("u01");
        @(negedge clk);
        check("u01_one_cycle", 32'(bus.out_valid), 32'd0);
        check("u01_idle_ready", 32'(bus.in_ready), 32'd1);

        do_op("u35", 8'h35, 1'b0);
        do_op("u80", 8'h80, 1'b0);
        do_op("sF3", 8'hF3, 1'b1);
        do_op("sFF", 8'hFF, 1'b1);
        do_op("s40", 8'h40, 1'b1);
        do_op("u00", 8'h00, 1'b0);
        do_op("s00", 8'h00, 1'b1);
        do_op("u02_after_zero", 8'h02, 1'b0);

        // Backpressure in DONE with a competing operand on the input.
        bus.out_ready = 1'b0;
        start_op(8'h35, 1'b0);
        wait_out(lat);
        compare_out("bp");
        bus.num         = 8'h11;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_hold_out",  32'(bus.out),       32'h0D4);
            check("bp_hold_shift", 32'(bus.shift_num), 32'd2);
            check("bp_hold_zero", 32'(bus.zero),      32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        do_op("bp_next", 8'h80, 1'b0);

        // Reset while the k=1 stage is pending.
        bus.num         = 8'h01;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_out",       32'(bus.out),       32'd0);
        check("mid_rst_shift",     32'(bus.shift_num), 32'd0);
        check("mid_rst_zero",      32'(bus.zero),      32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        check("mid_rst_no_stale", 32'(seen), 32'd0);

        // Every operand in both modes, with invariants on the returned word.
        for (int i = 0; i < 256; i++) begin
            for (int m = 0; m < 2; m++) begin
                vv = 8'(i);
                start_op(vv, 1'(m));
                wait_out(lat);
                if (bus.zero === 1'b0) begin
                    check("sweep_inv_shifted", 32'(bus.out), 32'(8'(vv << bus.shift_num)));
                    if (m == 0) check("sweep_inv_msb", 32'(bus.out[7]), 32'd1);
                    else        check("sweep_inv_sign", 32'(bus.out[7] ^ bus.out[6]), 32'd1);
                end
                compare_out("sweep");
                @(negedge clk);
            end
        end

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
